// File: rtl/add_pkg.sv
// Shared definitions for the adder result-side datapath.
//   - default widths and burst length for add_result_accum
//   - state encoding of the burst accumulator FSM
//   - type of one raw adder result: {carry, sum}
package add_pkg;

  localparam int ADD_DATA_W    = 8;
  localparam int ADD_ACC_W     = 16;
  localparam int ADD_BURST_LEN = 4;

  typedef logic [ADD_DATA_W:0] add_res_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/add_result_accum.sv
// add_result_accum: accumulates BURST_LEN adder results into one burst total.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   adder result valid
//   in_ready   result can be accepted this cycle (registered, low in HOLD)
//   in_sum     adder sum, DATA_W bits
//   in_carry   adder carry-out
//   clear      synchronous abort, drops any partial or pending burst
//   out_valid  burst total available
//   out_ready  consumer accepts the total
//   out_total  burst total, ACC_W bits, 0 when out_valid is low
//   out_count  samples in the burst, 0 when out_valid is low
//   out_ovf    some accumulation in the burst wrapped, 0 when out_valid is low
module add_result_accum
  import add_pkg::*;
#(
  parameter int DATA_W    = ADD_DATA_W,
  parameter int ACC_W     = ADD_ACC_W,
  parameter int BURST_LEN = ADD_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_carry,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  localparam logic [7:0] BURST_CNT = 8'(BURST_LEN);

  acc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              rdy_q, rdy_d;

  logic              accept;
  logic [ACC_W-1:0]  sample;
  logic [ACC_W:0]    add_w;
  logic [7:0]        cnt_inc;

  // clear wins over a simultaneous accept, so it gates the handshake itself.
  assign accept  = in_valid && rdy_q && !clear;
  assign sample  = ACC_W'({in_carry, in_sum});
  // One extra bit on the adder captures the wrap past 2^ACC_W.
  assign add_w   = {1'b0, acc_q} + {1'b0, sample};
  assign cnt_inc = cnt_q + 8'd1;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_d = (BURST_CNT == 8'd1) ? HOLD : ACCUM;
        end
        ACCUM: begin
          if (accept && (cnt_inc == BURST_CNT)) state_d = HOLD;
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Accumulator, counter and sticky overflow next values.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        // First sample of a burst restarts the total and the sticky flag.
        acc_d = sample;
        cnt_d = 8'd1;
        ovf_d = 1'b0;
      end else begin
        acc_d = add_w[ACC_W-1:0];
        cnt_d = cnt_inc;
        ovf_d = ovf_q | add_w[ACC_W];
      end
    end
  end

  // in_ready is registered from the next state, so it never depends
  // combinationally on out_ready and stays low throughout reset.
  assign rdy_d = (state_d != HOLD);

  // Outputs.
  always_comb begin
    in_ready  = rdy_q;
    out_valid = (state_q == HOLD);
    out_total = '0;
    out_count = '0;
    out_ovf   = 1'b0;
    if (state_q == HOLD) begin
      out_total = acc_q;
      out_count = cnt_q;
      out_ovf   = ovf_q;
    end
  end

endmodule
